// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: hex font, dark pattern and
// the all-digits-off common-line value.
package seg_pkg;

  // Segment pattern for a digit that must show nothing (dp included).
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Common lines are active-low; all ones deselects every digit. The scanner
  // slices the low NUM_DIGITS bits.
  localparam logic [7:0] COM_ALL_OFF = 8'hFF;

  // Full hex font, bit order {dp,g,f,e,d,c,b,a}; bit 7 is kept clear here and
  // filled from the per-digit decimal point.
  localparam logic [7:0] SEG_FONT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/seg_font_dec.sv
// Combinational digit decoder: 4-bit code plus decimal point to segment
// pattern, forced fully dark (dp included) when dark_i is set.
module seg_font_dec
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  input  logic       dark_i,
  output logic [7:0] seg_o
);

  // Font lookup with dark override.
  always_comb begin
    seg_o = SEG_OFF;
    if (!dark_i) begin
      seg_o = {dp_i, SEG_FONT[code_i][6:0]};
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with double-buffered display data.
//
// Scanning: a prescaler produces one tick every SCAN_DIV cycles; each tick
// registers the segments of the current index onto the pins and steps the
// index from NUM_DIGITS-1 down to 0. The tick at index 0 ends the frame.
//
// Update strobe: upd_req is a single-cycle strobe with no back-pressure. On
// the cycle it is high, all four input buses are captured into the shadow
// registers and upd_pending is set. The shadow is copied to the active
// registers on the next frame end, so a frame never mixes old and new data.
// A newer strobe simply overwrites the shadow (latest wins).
//
// Optional feature macro: SEG_SCAN_BLINK_EN enables blink_mask, the frame
// counter and the blink phase. Without it blink_mask is ignored.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    upd_req,
  output logic                    upd_pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   seg_com,
  output logic [7:0]              seg_data
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] COM_OFF  = COM_ALL_OFF[NUM_DIGITS-1:0];
  localparam logic [NUM_DIGITS-1:0] COM_ONE  = NUM_DIGITS'(1);

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic                    pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic [7:0]              data_q, data_d;
  logic                    tick, frame_end, commit;
  logic [3:0]              cur_code;
  logic                    cur_dp, dark, blink_dark;
  logic [7:0]              dec_seg;

  assign tick      = (presc_q == PRE_LAST);
  assign frame_end = tick && (idx_q == '0);
  assign commit    = frame_end && pend_q;

  // Prescaler and scan index stepping.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == '0) ? IDX_LAST : idx_q - 1'b1;
    end
  end

  // Shadow capture on strobe, shadow-to-active copy at frame end. A strobe on
  // the frame-end cycle commits the old shadow and keeps the new one pending.
  always_comb begin
    sh_dig_d    = upd_req ? digits_in : sh_dig_q;
    sh_dp_d     = upd_req ? dp_in     : sh_dp_q;
    sh_blank_d  = upd_req ? blank_in  : sh_blank_q;
    act_dig_d   = commit ? sh_dig_q   : act_dig_q;
    act_dp_d    = commit ? sh_dp_q    : act_dp_q;
    act_blank_d = commit ? sh_blank_q : act_blank_q;
    pend_d      = upd_req | (pend_q & ~frame_end);
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
  logic [FC_W-1:0]       fc_q, fc_d;
  logic                  phase_q, phase_d;

  // Blink mask buffering plus frame counter that flips the phase every
  // BLINK_FRAMES frame ends.
  always_comb begin
    sh_blink_d  = upd_req ? blink_mask : sh_blink_q;
    act_blink_d = commit ? sh_blink_q : act_blink_q;
    fc_d        = fc_q;
    phase_d     = phase_q;
    if (frame_end) begin
      if (fc_q == FC_LAST) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_blink_q  <= '0;
      act_blink_q <= '0;
      fc_q        <= '0;
      phase_q     <= 1'b0;
    end else begin
      sh_blink_q  <= sh_blink_d;
      act_blink_q <= act_blink_d;
      fc_q        <= fc_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_dark = phase_q & act_blink_q[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_FRAMES[0]};
  assign blink_dark   = 1'b0;
`endif

  assign cur_code = act_dig_q[4*idx_q +: 4];
  assign cur_dp   = act_dp_q[idx_q];
  assign dark     = act_blank_q[idx_q] | blink_dark;

  seg_font_dec u_font_dec (
    .code_i (cur_code),
    .dp_i   (cur_dp),
    .dark_i (dark),
    .seg_o  (dec_seg)
  );

  // Pin registers load the current slot on each tick and hold otherwise.
  always_comb begin
    com_d  = com_q;
    data_d = data_q;
    if (tick) begin
      com_d  = ~(COM_ONE << idx_q);
      data_d = dec_seg;
    end
  end

  // Scanner, buffer and pin state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= IDX_LAST;
      sh_dig_q    <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pend_q      <= 1'b0;
      com_q       <= COM_OFF;
      data_q      <= SEG_OFF;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      sh_dig_q    <= sh_dig_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pend_q      <= pend_d;
      com_q       <= com_d;
      data_q      <= data_d;
    end
  end

  assign upd_pending = pend_q;
  assign frame_done  = frame_end;
  assign seg_com     = com_q;
  assign seg_data    = data_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: 6 digits, 4 cycles per slot, 2 frames per blink
// half-period. Expected slots are pushed from a small font model and popped
// as the scanner presents each slot.
module tb_seg_scan_mux;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int BF = 2;
`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*ND-1:0] digits_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [ND-1:0] blank_in = '0;
  logic [ND-1:0] blink_mask = '0;
  logic          upd_req = 1'b0;
  logic          upd_pending, frame_done;
  logic [ND-1:0] seg_com;
  logic [7:0]    seg_data;

  logic [13:0] exp_q[$];
  logic [7:0]  font_tb [16];
  int n_vec = 0;
  int n_err = 0;

  seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_mask(blink_mask), .upd_req(upd_req),
    .upd_pending(upd_pending), .frame_done(frame_done),
    .seg_com(seg_com), .seg_data(seg_data)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [13:0] exp_slot(input logic [23:0] dig, input logic [5:0] dp,
                                           input logic [5:0] blank, input logic [5:0] blink,
                                           input logic phase, input int d);
    logic [3:0] code;
    logic [5:0] com;
    logic [7:0] seg;
    code = dig[4*d +: 4];
    com  = ~(6'b000001 << d);
    if (blank[d] || (phase && blink[d])) seg = 8'h00;
    else seg = {dp[d], font_tb[code][6:0]};
    return {com, seg};
  endfunction

  task automatic push_frame(input logic [23:0] dig, input logic [5:0] dp,
                            input logic [5:0] blank, input logic [5:0] blink, input logic phase);
    for (int d = ND - 1; d >= 0; d--) exp_q.push_back(exp_slot(dig, dp, blank, blink, phase, d));
  endtask

  // driver: one-cycle update strobe, starting from a negedge
  task automatic apply_update(input logic [23:0] dig, input logic [5:0] dp,
                              input logic [5:0] blank, input logic [5:0] blink);
    digits_in = dig; dp_in = dp; blank_in = blank; blink_mask = blink;
    upd_req = 1'b1;
    @(posedge clk);
    #1 upd_req = 1'b0;
  endtask

  task automatic wait_frame_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) break;
    end
    if (k == 100) begin
      n_vec++; n_err++;
      $display("FAIL frame_done_timeout no pulse within 100 cycles, need one within %0d", ND*SD);
    end
  endtask

  // scoreboard: sample n slots, first after lead negedges, then every SD
  task automatic sample_slots(input int n, input int lead);
    logic [13:0] e;
    for (int j = 0; j < n; j++) begin
      repeat (j == 0 ? lead : SD) @(negedge clk);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL slot_queue_empty got com=%h seg=%h", seg_com, seg_data);
      end else begin
        e = exp_q.pop_front();
        if ({seg_com, seg_data} !== e) begin
          n_err++;
          $display("FAIL slot%0d got com=%h seg=%h need com=%h seg=%h",
                   j, seg_com, seg_data, e[13:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec += 4;
    if (seg_com !== 6'h3F) begin n_err++; $display("FAIL rst_com got %h need 3f", seg_com); end
    if (seg_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h need 00", seg_data); end
    if (upd_pending !== 1'b0) begin n_err++; $display("FAIL rst_pending got %b need 0", upd_pending); end
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got %b need 0", frame_done); end
    rst = 1'b0;
    repeat (SD - 1) @(negedge clk);
    n_vec++;
    if (seg_com !== 6'h3F) begin n_err++; $display("FAIL early_com got %h need 3f", seg_com); end
    push_frame(24'h000000, 6'h00, 6'h00, 6'h00, 1'b0);
    sample_slots(6, 1);
  endtask

  task automatic test_frame_period();
    int cnt;
    wait_frame_done();
    @(negedge clk);
    n_vec++;
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL frame_done_width got %b need 0", frame_done); end
    cnt = 1;
    while (cnt < 100 && frame_done !== 1'b1) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt != ND*SD) begin n_err++; $display("FAIL frame_period got %0d need %0d", cnt, ND*SD); end
  endtask

  task automatic test_basic();
    apply_update(24'h123456, 6'h00, 6'h00, 6'h00);
    @(negedge clk);
    n_vec++;
    if (upd_pending !== 1'b1) begin n_err++; $display("FAIL basic_pending_rise got %b need 1", upd_pending); end
    wait_frame_done();
    @(negedge clk);
    n_vec++;
    if (upd_pending !== 1'b0) begin n_err++; $display("FAIL basic_pending_fall got %b need 0", upd_pending); end
    push_frame(24'h123456, 6'h00, 6'h00, 6'h00, 1'b0);
    sample_slots(6, SD);
  endtask

  task automatic test_mid_update();
    wait_frame_done();
    repeat (9) @(negedge clk);
    apply_update(24'h999999, 6'h00, 6'h00, 6'h00);
    @(negedge clk);
    n_vec += 2;
    if (upd_pending !== 1'b1) begin n_err++; $display("FAIL mid_pending got %b need 1", upd_pending); end
    if ({seg_com, seg_data} !== {6'h2F, 8'h5B}) begin
      n_err++; $display("FAIL mid_old_slot got com=%h seg=%h need com=2f seg=5b", seg_com, seg_data);
    end
    wait_frame_done();
    n_vec++;
    if (upd_pending !== 1'b1) begin n_err++; $display("FAIL mid_pending_at_end got %b need 1", upd_pending); end
    @(negedge clk);
    n_vec += 2;
    if (upd_pending !== 1'b0) begin n_err++; $display("FAIL mid_pending_fall got %b need 0", upd_pending); end
    if ({seg_com, seg_data} !== {6'h3E, 8'h7D}) begin
      n_err++; $display("FAIL mid_last_old got com=%h seg=%h need com=3e seg=7d", seg_com, seg_data);
    end
    push_frame(24'h999999, 6'h00, 6'h00, 6'h00, 1'b0);
    sample_slots(6, SD);
  endtask

  task automatic test_back_to_back();
    wait_frame_done();
    repeat (3) @(negedge clk);
    apply_update(24'h111111, 6'h00, 6'h00, 6'h00);
    repeat (3) @(negedge clk);
    apply_update(24'h222222, 6'h00, 6'h00, 6'h00);
    @(negedge clk);
    n_vec++;
    if (upd_pending !== 1'b1) begin n_err++; $display("FAIL b2b_pending got %b need 1", upd_pending); end
    wait_frame_done();
    @(negedge clk);
    push_frame(24'h222222, 6'h00, 6'h00, 6'h00, 1'b0);
    sample_slots(6, SD);
  endtask

  task automatic test_upd_at_frame_end();
    wait_frame_done();
    repeat (2) @(negedge clk);
    apply_update(24'h777777, 6'h00, 6'h00, 6'h00);
    wait_frame_done();
    apply_update(24'h888888, 6'h00, 6'h00, 6'h00);
    @(negedge clk);
    n_vec += 2;
    if (upd_pending !== 1'b1) begin n_err++; $display("FAIL fe_pending_kept got %b need 1", upd_pending); end
    if ({seg_com, seg_data} !== {6'h3E, 8'h5B}) begin
      n_err++; $display("FAIL fe_last_old got com=%h seg=%h need com=3e seg=5b", seg_com, seg_data);
    end
    push_frame(24'h777777, 6'h00, 6'h00, 6'h00, 1'b0);
    sample_slots(6, SD);
    n_vec++;
    if (upd_pending !== 1'b0) begin n_err++; $display("FAIL fe_pending_fall got %b need 0", upd_pending); end
    wait_frame_done();
    @(negedge clk);
    push_frame(24'h888888, 6'h00, 6'h00, 6'h00, 1'b0);
    sample_slots(6, SD);
  endtask

  task automatic test_blank_dp();
    apply_update(24'h123456, 6'h02, 6'h20, 6'h00);
    wait_frame_done();
    @(negedge clk);
    push_frame(24'h123456, 6'h02, 6'h20, 6'h00, 1'b0);
    sample_slots(6, SD);
  endtask

  task automatic test_random();
    logic [23:0] dig;
    logic [5:0]  dp, blank;
    for (int i = 0; i < 3; i++) begin
      dig   = 24'($urandom);
      dp    = 6'($urandom_range(0, 63));
      blank = 6'($urandom_range(0, 63));
      apply_update(dig, dp, blank, 6'h00);
      wait_frame_done();
      @(negedge clk);
      push_frame(dig, dp, blank, 6'h00, 1'b0);
      sample_slots(6, SD);
    end
  endtask

  task automatic test_reset_pending();
    wait_frame_done();
    repeat (6) @(negedge clk);
    apply_update(24'h999999, 6'h00, 6'h00, 6'h00);
    @(negedge clk);
    n_vec++;
    if (upd_pending !== 1'b1) begin n_err++; $display("FAIL rp_pending got %b need 1", upd_pending); end
    rst = 1'b1;
    #1;
    n_vec += 3;
    if (seg_com !== 6'h3F) begin n_err++; $display("FAIL rp_com got %h need 3f", seg_com); end
    if (seg_data !== 8'h00) begin n_err++; $display("FAIL rp_data got %h need 00", seg_data); end
    if (upd_pending !== 1'b0) begin n_err++; $display("FAIL rp_pending_clr got %b need 0", upd_pending); end
    @(negedge clk);
    rst = 1'b0;
    push_frame(24'h000000, 6'h00, 6'h00, 6'h00, 1'b0);
    sample_slots(6, SD);
  endtask

  task automatic test_blink();
    logic ph;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    apply_update(24'h123456, 6'h00, 6'h00, 6'h03);
    wait_frame_done();
    for (int f = 1; f <= 7; f++) begin
      ph = BLINK_EN && (((f / BF) % 2) == 1);
      push_frame(24'h123456, 6'h00, 6'h00, 6'h03, ph);
    end
    sample_slots(7 * ND, SD + 1);
  endtask

  initial begin
    font_tb = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    test_reset();
    test_frame_period();
    test_basic();
    test_mid_update();
    test_back_to_back();
    test_upd_at_frame_end();
    test_blank_dp();
    test_random();
    test_reset_pending();
    test_blink();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed seven-segment scanner, successor to the clock's fixed six-digit display driver. Drives NUM_DIGITS common-cathode-style digits from a packed BCD/hex bus, with per-digit decimal point, blanking and blink. Display data is double-buffered and committed only at frame boundaries, so digits never tear mid-scan. Sits between the timekeeping/alarm logic and the board's 7-segment pins.

## Interface
- NUM_DIGITS, 6, number of scanned digits (1..8)
- SCAN_DIV, 4, clk cycles per digit slot (≥2)
- BLINK_FRAMES, 64, frames per blink half-period (≥1)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- digits_in  in  4*NUM_DIGITS  nibble i = code for digit i (digit 0 rightmost)
- dp_in  in  NUM_DIGITS  decimal point enable per digit
- blank_in  in  NUM_DIGITS  force digit i dark
- blink_mask  in  NUM_DIGITS  digit i blinks
- upd_req  in  1  one-cycle strobe: capture all four input buses into shadow
- upd_pending  out  1  shadow holds data not yet committed
- frame_done  out  1  one-cycle pulse at each frame end
- seg_com  out  NUM_DIGITS  digit select, active-low one-hot
- seg_data  out  8  {dp,g,f,e,d,c,b,a}, active-high

## Operation
- Prescaler counts 0..SCAN_DIV-1; scan tick when it equals SCAN_DIV-1.
- Scan index runs NUM_DIGITS-1 down to 0, wraps to NUM_DIGITS-1; advances on tick.
- Frame end = tick while index is 0; frame_done pulses that cycle.
- Shadow regs (digits, dp, blank, blink) load on upd_req; upd_pending set.
- At frame end with upd_pending=1: shadow → active, upd_pending cleared.
- upd_req while pending: shadow overwritten, latest wins, pending stays 1.
- upd_req on frame-end cycle: old shadow commits to active, new data enters shadow, pending stays 1.
- Font: full hex 0-F (0→0x3F, 1→0x06, 8→0x7F, A→0x77, F→0x71).
- Digit dark (seg_data=0x00, including dp) if active blank bit set, or blink phase=1 and active blink bit set; seg_com still selects it.
- Blink phase toggles after every BLINK_FRAMES frame ends; frame counter wraps to 0 on toggle.

## Timing
- Reset: prescaler 0, index NUM_DIGITS-1, active and shadow regs 0, blink phase 0, upd_pending 0, frame_done 0, seg_com all-ones, seg_data 0x00.
- seg_com/seg_data are registered, updated the cycle after the scan tick (1-cycle latency from index change).
- First digit appears SCAN_DIV cycles after reset release; frame period NUM_DIGITS*SCAN_DIV cycles.
- upd_pending rises the cycle after upd_req; falls the cycle after committing frame end.
- Committed data visible from first slot of the next frame.
- Reset mid-frame: all state returns to reset values immediately; pending data discarded.

## Configuration
- SEG_SCAN_BLINK_EN defined: blink counter, phase and blink_mask path present as above.
- Undefined: blink_mask ignored (not registered), no frame counter, phase constant 0; BLINK_FRAMES unused.

## Structure
- Package seg_pkg: 16-entry font constant array, SEG_OFF = 8'h00, com encoding helper constant for all-off.
- One sub-module: seg_font_dec (4-bit code + dp + dark → 8-bit seg_data, combinational).

## Test plan
- NUM_DIGITS=6, SCAN_DIV=4, digits_in=0x123456 committed -> seg_com cycles 0x1F→0x2F→…→0x3E, seg_data 0x06,0x5B,0x4F,0x66,0x6D,0x7D; frame 24 cycles.
- upd_req mid-frame with 0x999999 -> old digits until frame end; upd_pending high ~until frame_done, then all slots 0x6F.
- Two upd_req in one frame (0x111111 then 0x222222) -> only 0x5B appears next frame.
- blink_mask=0x03, BLINK_FRAMES=2 -> digits 0,1 show 0x00 on frames 2-3, 6-7; others unaffected. Without SEG_SCAN_BLINK_EN -> never dark.
- blank_in=0x20, dp_in=0x02 -> digit 5 slot 0x00; digit 1 has bit7 set.
- Assert rst mid-frame with pending -> seg_com all-ones, upd_pending 0 immediately; after release, digits 0x3F.
